// File: rtl/shift_pkg.sv
// Shared definitions for the serial-to-parallel capture block.
package shift_pkg;

    // Capture FSM encodings; 2'b11 is unreachable and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronous level input.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Previous sample; resets high so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/shift_in_param.sv
// Serial-to-parallel word capture: a rising edge on sx starts a WIDTH-bit capture,
// fx flags the finished word until the consumer acks it.
module shift_in_param
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 12,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_in,
    input  logic             sx,
    input  logic             ack,
    output logic [WIDTH-1:0] x_parallel,
    output logic             fx,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  xp_q, xp_d;
    logic              fx_q, fx_d;
    logic              busy_q, busy_d;
    logic              start;

    rise_detect u_rise_detect (
        .clk  (clk),
        .reset(reset),
        .d    (sx),
        .rise (start)
    );

    // Next-state logic; a start edge overrides everything, including a same-cycle ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xp_d    = xp_q;
        fx_d    = fx_q;
        busy_d  = busy_q;
        if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            xp_d    = '0;
            fx_d    = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    fx_d   = 1'b0;
                    busy_d = 1'b0;
                end
                SHIFT: begin
                    xp_d  = MSB_FIRST ? {xp_q[WIDTH-2:0], x_in} : {x_in, xp_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = DONE;
                        fx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        fx_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    xp_d    = '0;
                    fx_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter and all outputs registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xp_q    <= '0;
            fx_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xp_q    <= xp_d;
            fx_q    <= fx_d;
            busy_q  <= busy_d;
        end
    end

    assign x_parallel = xp_q;
    assign fx         = fx_q;
    assign busy       = busy_q;

endmodule
